fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage feeding `decode_stage`. Holds the architectural fetch PC and a single-line fetch buffer refilled from instruction memory over a request/ready handshake. Presents one registered instruction per cycle to decode. Obeys decode back-pressure (`stall_in`) and redirects on resolved jumps (`jump_taken`/`jump_addr`).

## Interface
Parameters:
- `WORD_SIZE`, `` `WORD_SIZE `` (32): instruction/address width.
- `LINE_SIZE`, `` `CACHE_LINE_SIZE `` (128): memory line width in bits; 4 words per line.
- `RESET_PC`, `` `RESET_PC `` (32'h0000_1000): PC loaded on reset.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_in`  in  1  decode back-pressure; driven by decode's `stall_out`.
- `jump_taken`  in  1  redirect request; flushes the output register.
- `jump_addr`  in  WORD_SIZE  redirect target.
- `mem_req`  out  1  line fill request. Held until `mem_ready`.
- `mem_addr`  out  WORD_SIZE  line-aligned fill address; low 4 bits are 0.
- `mem_ready`  in  1  one-cycle pulse; `mem_data` is valid in that cycle.
- `mem_data`  in  LINE_SIZE  fill line. Word 0 is in bits [31:0].
- `instruction`  out  WORD_SIZE  instruction to decode.
- `valid`  out  1  `instruction` is valid.
- `pc_out`  out  WORD_SIZE  PC of `instruction`.

## Operation
- State: `pc`, `buf_valid`, `buf_tag` (= `pc[WORD_SIZE-1:4]`), `buf_line`, FSM `{IDLE, MISS}`.
- Hit: `buf_valid && buf_tag == pc[WORD_SIZE-1:4]`. Word select is `pc[3:2]`.
- IDLE, `stall_in=0`, `jump_taken=0`:
  - On hit: `instruction` <= selected word, `pc_out` <= `pc`, `valid` <= 1, `pc` <= `pc`+4 (wraps modulo 2^WORD_SIZE).
  - On miss: `valid` <= 0, `mem_req` <= 1, `mem_addr` <= {`pc[WORD_SIZE-1:4]`, 4'b0}, state <= MISS.
- IDLE, `stall_in=1`, `jump_taken=0`: `instruction`, `valid`, `pc_out` and `pc` all hold.
- MISS:
  - `mem_req` stays high and `mem_addr` stays stable until `mem_ready`.
  - On `mem_ready`: `buf_line` <= `mem_data`, `buf_tag` <= `mem_addr[WORD_SIZE-1:4]`, `buf_valid` <= 1, `mem_req` <= 0, state <= IDLE.
  - While in MISS: `valid` <= 0 unless stalled. If stalled, the output register holds.
- `jump_taken=1`, in any state, has priority over `stall_in`:
  - `pc` <= {`jump_addr[WORD_SIZE-1:2]`, 2'b00}; `valid` <= 0.
  - In MISS, the outstanding request is not cancelled. Returned data is still written into the buffer, because it is correct for its address. State then returns to IDLE, and the next cycle checks for a hit against the new `pc`.
- `mem_ready` outside MISS is ignored.
- Reset mid-fill: FSM returns to IDLE and `buf_valid` is cleared. A later stale `mem_ready` is ignored.

## Timing
- Reset values: `pc`=RESET_PC, `valid`=0, `instruction`=`` `NOP `` (32'h0000_0013), `pc_out`=0, `mem_req`=0, `mem_addr`=0, `buf_valid`=0, state IDLE.
- Hit: `valid`/`instruction` are registered. They appear one cycle after the edge on which the hit is evaluated. Throughput is 1 instruction/cycle while hitting.
- Miss timing, with memory latency L cycles (request edge to `mem_ready`):
  - `mem_req` rises 1 cycle after the miss is detected.
  - The buffer fills on the `mem_ready` edge.
  - The first valid instruction appears 2 cycles after `mem_ready`: 1 cycle to return to IDLE, 1 cycle for the hit evaluation.
- Redirect: `valid`=0 in the cycle after `jump_taken`. The first target instruction appears 2 cycles after `jump_taken` on a hit.

## Structure
- Shared defines header: `` `WORD_SIZE ``, `` `CACHE_LINE_SIZE ``, `` `RESET_PC ``, `` `NOP ``, and the fetch FSM state encoding (`` `FETCH_IDLE ``, `` `FETCH_MISS ``).
- One sub-module, `fetch_line_buffer`: tag/valid/line registers, fill port, hit compare, word-select mux. The FSM, PC and output register stay in `fetch_stage`.

## Test plan
- Cold start: release `rst`; memory returns line {13,23,33,43} (word0..3) with L=3.
  - `mem_req`=1 with `mem_addr`=0x1000 until `mem_ready`.
  - Then `valid`=1 with `instruction`=13 and `pc_out`=0x1000, followed by 23, 33, 43 on consecutive cycles.
- Line crossing: after `pc_out`=0x100C, `mem_req` rises with `mem_addr`=0x1010, and `valid` drops to 0 until the fill completes.
- Stall: assert `stall_in` for 3 cycles while showing `pc_out`=0x1004. Outputs hold at 0x1004; 0x1008 follows the cycle after release.
- Jump hit: `jump_taken`=1 with `jump_addr`=0x1009.
  - Next cycle `valid`=0.
  - Then `pc_out`=0x1008 (low bits forced to zero) with no `mem_req`.
- Jump during miss: while `mem_req` is pending for 0x1010, jump to 0x2000.
  - The 0x1010 fill completes and is tagged 0x101.
  - A new `mem_req` is issued for 0x2000.
  - No instruction from 0x1010 is ever shown as valid.
- Jump and stall together: `jump_taken`=1 and `stall_in`=1 in the same cycle. The redirect wins: `valid`=0 and `pc` is set to the target.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and FSM state encoding.
package fetch_stage_pkg;

    localparam int unsigned WORD_SIZE       = 32;
    localparam int unsigned CACHE_LINE_SIZE = 128;
    localparam logic [31:0] RESET_PC        = 32'h0000_1000;
    localparam logic [31:0] NOP             = 32'h0000_0013;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_MISS
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory line-fill handshake between fetch (master) and memory (slave).
interface fetch_stage_if #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned LINE_SIZE = 128
);

    logic                 mem_req;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_ready;
    logic [LINE_SIZE-1:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_data
    );

endinterface

// File: rtl/fetch_line_buffer.sv
// Single-line fetch buffer: tag/valid/line registers, fill port, hit compare and word select.
module fetch_line_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned WORD_SIZE = fetch_stage_pkg::WORD_SIZE,
    parameter int unsigned LINE_SIZE = fetch_stage_pkg::CACHE_LINE_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_fill,
    input  logic [WORD_SIZE-5:0] i_fill_tag,
    input  logic [LINE_SIZE-1:0] i_fill_line,
    input  logic [WORD_SIZE-5:0] i_tag,
    input  logic [1:0]           i_word_sel,
    output logic                 o_hit,
    output logic [WORD_SIZE-1:0] o_word
);

    logic                 r_valid;
    logic [WORD_SIZE-5:0] r_tag;
    logic [LINE_SIZE-1:0] r_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_line  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_tag;
            r_line  <= i_fill_line;
        end
    end

    always_comb begin
        o_hit  = r_valid && (r_tag == i_tag);
        o_word = r_line[32'(i_word_sel) * WORD_SIZE +: WORD_SIZE];
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, miss FSM and registered instruction output to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          WORD_SIZE = fetch_stage_pkg::WORD_SIZE,
    parameter int unsigned          LINE_SIZE = fetch_stage_pkg::CACHE_LINE_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(fetch_stage_pkg::RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic                 jump_taken,
    input  logic [WORD_SIZE-1:0] jump_addr,
    fetch_stage_if.master        mem,
    output logic [WORD_SIZE-1:0] instruction,
    output logic                 valid,
    output logic [WORD_SIZE-1:0] pc_out
);

    fetch_state_e         r_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_instruction;
    logic                 r_valid;
    logic [WORD_SIZE-1:0] r_pc_out;
    logic                 r_mem_req;
    logic [WORD_SIZE-1:0] r_mem_addr;

    logic                 w_fill;
    logic                 w_hit;
    logic [WORD_SIZE-1:0] w_word;
    logic [WORD_SIZE-1:0] w_jump_pc;

    // A fill is only accepted while a request is outstanding; stale pulses are dropped.
    assign w_fill    = (r_state == FETCH_MISS) && mem.mem_ready;
    assign w_jump_pc = jump_addr & ~WORD_SIZE'(3);

    fetch_line_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .LINE_SIZE (LINE_SIZE)
    ) u_line_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_fill      (w_fill),
        .i_fill_tag  (r_mem_addr[WORD_SIZE-1:4]),
        .i_fill_line (mem.mem_data),
        .i_tag       (r_pc[WORD_SIZE-1:4]),
        .i_word_sel  (r_pc[3:2]),
        .o_hit       (w_hit),
        .o_word      (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH_IDLE;
            r_pc          <= RESET_PC;
            r_instruction <= WORD_SIZE'(NOP);
            r_valid       <= 1'b0;
            r_pc_out      <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
        end else begin
            unique case (r_state)
                FETCH_IDLE: begin
                    if (!jump_taken && !stall_in) begin
                        if (w_hit) begin
                            r_instruction <= w_word;
                            r_pc_out      <= r_pc;
                            r_valid       <= 1'b1;
                            r_pc          <= r_pc + WORD_SIZE'(4);
                        end else begin
                            r_valid    <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {r_pc[WORD_SIZE-1:4], 4'b0000};
                            r_state    <= FETCH_MISS;
                        end
                    end
                end
                FETCH_MISS: begin
                    if (mem.mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= FETCH_IDLE;
                    end
                    if (!jump_taken && !stall_in) begin
                        r_valid <= 1'b0;
                    end
                end
            endcase
            // Redirect overrides stall; an outstanding fill still completes into the buffer.
            if (jump_taken) begin
                r_pc    <= w_jump_pc;
                r_valid <= 1'b0;
            end
        end
    end

    assign instruction  = r_instruction;
    assign valid        = r_valid;
    assign pc_out       = r_pc_out;
    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;

endmodule
